// File: rtl/reg_file_wb.sv
// reg_file_wb: 2^ADDR_W x DATA_W register file with two async read ports, one write-back port, r0 hardwired to zero
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic [31:0]       wrCount,
    output logic              wrAck
);
    localparam int N = 1 << ADDR_W;
    logic [DATA_W-1:0] regs_q [N];
    logic [31:0]       wr_count_q, wr_count_d;
    logic              wr_ack_q, wr_ack_d;
    logic              commit;
    // Writes to r0 are swallowed: no storage, no count, no ack
    assign commit = wrEn && (wrAddr != '0);
    always_comb begin
        wr_count_d = commit ? wr_count_q + 32'd1 : wr_count_q;
        wr_ack_d   = commit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            wr_count_q <= '0;
            wr_ack_q   <= 1'b0;
        end else begin
            if (commit) regs_q[wrAddr] <= wrData;
            wr_count_q <= wr_count_d;
            wr_ack_q   <= wr_ack_d;
        end
    end
    assign rdData1 = (rdAddr1 == '0) ? '0 : regs_q[rdAddr1];
    assign rdData2 = (rdAddr2 == '0) ? '0 : regs_q[rdAddr2];
    assign wrCount = wr_count_q;
    assign wrAck   = wr_ack_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: scoreboard bench; stimulus queues expectations, a negedge monitor pops and compares
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rdAddr1, rdAddr2, wrAddr;
    logic [31:0] rdData1, rdData2, wrData, wrCount;
    logic        wrEn, wrAck;
    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] cnt;
        logic        ack;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ack_q[$];
    exp_t        e;
    logic [31:0] c;
    logic        chk_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_cnt = 0;
    reg_file_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .rdData1(rdData1), .rdData2(rdData2),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .wrCount(wrCount), .wrAck(wrAck)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: check strobe with empty scoreboard");
            end else begin
                e = exp_q.pop_front();
                if (rdData1 !== e.rd1 || rdData2 !== e.rd2 || wrCount !== e.cnt || wrAck !== e.ack) begin
                    errors++;
                    $display("FAIL %s: got rd1=%h rd2=%h cnt=%0d ack=%b, expected rd1=%h rd2=%h cnt=%0d ack=%b",
                             e.name, rdData1, rdData2, wrCount, wrAck, e.rd1, e.rd2, e.cnt, e.ack);
                end
            end
        end
        if (wrAck === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack: unexpected wrAck with wrCount=%0d", wrCount);
            end else begin
                c = ack_q.pop_front();
                if (wrCount !== c) begin
                    errors++;
                    $display("FAIL ack_count: got wrCount=%0d at ack, expected %0d", wrCount, c);
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic write(input logic [4:0] a, input logic [31:0] d);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        if (a != 0) begin
            m_cnt++;
            ack_q.push_back(m_cnt);
        end
        tick();
        wrEn = 1'b0;
    endtask
    task automatic check(input string n, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] ec, input logic ea);
        exp_t x;
        x.name = n; x.rd1 = e1; x.rd2 = e2; x.cnt = ec; x.ack = ea;
        rdAddr1 = a1; rdAddr2 = a2;
        exp_q.push_back(x);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1'b1; wrEn = 1'b0; wrAddr = 0; wrData = 0; rdAddr1 = 0; rdAddr2 = 0;
        tick(); tick();
        rst = 1'b0;
        check("reset_init", 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 1'b0);
        // reset clears a previously written register
        write(5'd5, 32'h1234);
        check("r5_written", 5'd5, 5'd5, 32'h1234, 32'h1234, 32'd1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; m_cnt = 0;
        check("reset_clears", 5'd5, 5'd5, 32'd0, 32'd0, 32'd0, 1'b0);
        // back-to-back write-back: memory path then result path
        write(5'd8, 32'd500);
        write(5'd9, 32'd400);
        check("r8_r9", 5'd8, 5'd9, 32'd500, 32'd400, 32'd2, 1'b1);
        check("r9_r8", 5'd9, 5'd8, 32'd400, 32'd500, 32'd2, 1'b0);
        write(5'd0, 32'hFFFF_FFFF);
        check("r0_write", 5'd0, 5'd8, 32'd0, 32'd500, 32'd2, 1'b0);
        // read-during-write returns the old value until the edge
        write(5'd3, 32'd7);
        check("r3_init", 5'd3, 5'd3, 32'd7, 32'd7, 32'd3, 1'b1);
        tick();
        wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'd99;
        m_cnt++; ack_q.push_back(m_cnt);
        check("rdw_before", 5'd3, 5'd3, 32'd7, 32'd7, 32'd3, 1'b0);
        tick();
        wrEn = 1'b0;
        check("rdw_after", 5'd3, 5'd3, 32'd99, 32'd99, 32'd4, 1'b1);
        // reset wins over a same-edge write
        rst = 1'b1; wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'd55;
        tick();
        rst = 1'b0; wrEn = 1'b0; m_cnt = 0;
        check("rst_prio", 5'd4, 5'd3, 32'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i < 32; i++) begin
            write(i[4:0], i * 3);
            if (i == 16) begin
                tick();
                check("idle_gap", 5'd16, 5'd15, 32'd48, 32'd45, 32'd16, 1'b0);
            end
        end
        for (int i = 0; i < 32; i++)
            check("sweep", i[4:0], 5'(31 - i), i * 3, (31 - i) * 3, 32'd31, i == 0);
        tick();
        checks++;
        if (ack_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d acks and %0d checks still pending, expected 0 and 0",
                     ack_q.size(), exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
